// File: rtl/paddsub_serial_16bit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | paddsub_serial_16bit: nibble-serial saturating add/sub (PADDSUB / ADD16)  |
// | Optional sat_lanes output enabled by `define PADDSUB_LANE_FLAGS_EN        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module paddsub_serial_16bit #(
  parameter int LANES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic        sub,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        ovf,
  output logic        zero
`ifdef PADDSUB_LANE_FLAGS_EN
  ,
  output logic [3:0]  sat_lanes
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] c_LAST_LANE = 2'(LANES - 1);

  state_t      r_state;
  logic [1:0]  r_lane;
  logic        r_carry;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic        r_mode;
  logic        r_sub;
  logic [3:0]  r_sat;
  logic [15:0] r_result;
  logic        r_busy;
  logic        r_done;
  logic        r_ovf;
  logic        r_zero;

  logic [3:0]  w_a_n;
  logic [3:0]  w_b_n;
  logic [3:0]  w_b_eff;
  logic [4:0]  w_add;
  logic [4:0]  w_b_ps;
  logic [4:0]  w_ps_sum;
  logic        w_ps_clamp;
  logic [3:0]  w_ps_nib;
  logic [3:0]  w_lane_nib;
  logic        w_lane_sat;
  logic [3:0]  w_sat_vec;
  logic        w_a16_ovf;
  logic [15:0] w_final;
  logic        w_final_ovf;

  always_comb begin
    w_a_n    = r_a[{r_lane, 2'b00} +: 4];
    w_b_n    = r_b[{r_lane, 2'b00} +: 4];
    w_b_eff  = r_sub ? ~w_b_n : w_b_n;
    w_add    = {1'b0, w_a_n} + {1'b0, w_b_eff} + {4'b0, r_carry};
    // PADDSUB negates in 5 bits so that 0x8 subtracts as +8
    w_b_ps   = r_sub ? (~{w_b_n[3], w_b_n} + 5'd1) : {w_b_n[3], w_b_n};
    w_ps_sum = {w_a_n[3], w_a_n} + w_b_ps;
    w_ps_clamp = w_ps_sum[4] ^ w_ps_sum[3];
    w_ps_nib   = w_ps_clamp ? (w_ps_sum[4] ? 4'h8 : 4'h7) : w_ps_sum[3:0];
    w_lane_nib = r_mode ? w_add[3:0] : w_ps_nib;
    w_lane_sat = ~r_mode & w_ps_clamp;
    w_sat_vec  = r_sat | ({3'b0, w_lane_sat} << r_lane);
    w_a16_ovf  = (w_a_n[3] == w_b_eff[3]) && (w_add[3] != w_a_n[3]);
    if (r_mode && w_a16_ovf)
      w_final = w_a_n[3] ? 16'h8000 : 16'h7FFF;
    else
      w_final = {w_lane_nib, r_result[11:0]};
    w_final_ovf = r_mode ? w_a16_ovf : |w_sat_vec;
  end

`ifdef PADDSUB_LANE_FLAGS_EN
  logic [3:0] r_sat_lanes;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_sat_lanes <= 4'h0;
    else if (r_state == S_BUSY && r_lane == c_LAST_LANE)
      r_sat_lanes <= r_mode ? {4{w_a16_ovf}} : w_sat_vec;
  end
  assign sat_lanes = r_sat_lanes;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_lane   <= 2'd0;
      r_carry  <= 1'b0;
      r_a      <= 16'h0;
      r_b      <= 16'h0;
      r_mode   <= 1'b0;
      r_sub    <= 1'b0;
      r_sat    <= 4'h0;
      r_result <= 16'h0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_mode  <= mode;
            r_sub   <= sub;
            r_lane  <= 2'd0;
            r_carry <= sub;
            r_sat   <= 4'h0;
            r_busy  <= 1'b1;
            r_state <= S_BUSY;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_BUSY: begin
          r_carry <= w_add[4];
          r_sat   <= w_sat_vec;
          r_lane  <= r_lane + 2'd1;
          if (r_lane == c_LAST_LANE) begin
            r_result <= w_final;
            r_ovf    <= w_final_ovf;
            r_zero   <= (w_final == 16'h0);
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_DONE;
          end else begin
            r_result[{r_lane, 2'b00} +: 4] <= w_lane_nib;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign ovf    = r_ovf;
  assign zero   = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_paddsub_serial_16bit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_paddsub_serial_16bit: scoreboard bench for paddsub_serial_16bit        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_paddsub_serial_16bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] a = 16'h0;
  logic [15:0] b = 16'h0;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        ovf;
  logic        zero;
`ifdef PADDSUB_LANE_FLAGS_EN
  logic [3:0]  sat_lanes;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic [17:0] sb_q[$];

  paddsub_serial_16bit #(.LANES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .sub(sub),
    .a(a), .b(b), .busy(busy), .done(done), .result(result),
    .ovf(ovf), .zero(zero)
`ifdef PADDSUB_LANE_FLAGS_EN
    , .sat_lanes(sat_lanes)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expected {result, ovf, zero}
  always @(negedge clk) begin
    if (done) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: got result %h with no pending op", result);
      end else begin
        logic [17:0] exp;
        exp = sb_q.pop_front();
        if ({result, ovf, zero} !== exp) begin
          n_fail++;
          $display("FAIL op_result: got r=%h v=%b z=%b expected r=%h v=%b z=%b",
                   result, ovf, zero, exp[17:2], exp[1], exp[0]);
        end
      end
    end
  end

  task automatic run_op(input logic m, input logic s, input logic [15:0] ta,
                        input logic [15:0] tb_v, input logic [15:0] er,
                        input logic eo, input logic ez);
    int n, nb;
    @(negedge clk);
    start = 1'b1; mode = m; sub = s; a = ta; b = tb_v;
    sb_q.push_back({er, eo, ez});
    @(negedge clk);
    start = 1'b0;
    n  = 0;
    nb = busy ? 1 : 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (busy) nb++;
    end
    check("done_latency", n, 4);
    check("busy_cycles", nb, 4);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("reset_state", {busy, done, result, ovf, zero}, 20'h0);
    rst = 1'b0;

    // PADDSUB
    run_op(1'b0, 1'b0, 16'h7351, 16'h1234, 16'h7575, 1'b1, 1'b0);
    run_op(1'b0, 1'b1, 16'h0000, 16'h8888, 16'h7777, 1'b1, 1'b0);
    run_op(1'b0, 1'b1, 16'h8000, 16'h1000, 16'h8000, 1'b1, 1'b0);
    run_op(1'b0, 1'b1, 16'h1234, 16'h1111, 16'h0123, 1'b0, 1'b0);
    run_op(1'b0, 1'b0, 16'hF9A3, 16'h1F2E, 16'h08C1, 1'b0, 1'b0);
    // ADD16
    run_op(1'b1, 1'b0, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b1, 1'b0);
    run_op(1'b1, 1'b0, 16'h1234, 16'h0FCC, 16'h2200, 1'b0, 1'b0);
    run_op(1'b1, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b1);
    run_op(1'b1, 1'b1, 16'h8000, 16'h0001, 16'h8000, 1'b1, 1'b0);
    run_op(1'b1, 1'b1, 16'h0000, 16'h8000, 16'h7FFF, 1'b1, 1'b0);
    run_op(1'b1, 1'b1, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1);

    // start pulsed while busy must be ignored
    @(negedge clk);
    start = 1'b1; mode = 1'b1; sub = 1'b0; a = 16'h1234; b = 16'h0FCC;
    sb_q.push_back({16'h2200, 1'b0, 1'b0});
    @(negedge clk);
    start = 1'b1; mode = 1'b0; sub = 1'b1; a = 16'hFFFF; b = 16'h0001;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);

    // async reset in the middle of an op
    run_op(1'b1, 1'b0, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b1; mode = 1'b0; sub = 1'b0; a = 16'h7351; b = 16'h1234;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_reset", {busy, result, ovf}, 18'h0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // back-to-back: start held through the DONE cycle
    @(negedge clk);
    start = 1'b1; mode = 1'b1; sub = 1'b1; a = 16'h0005; b = 16'h0005;
    sb_q.push_back({16'h0000, 1'b0, 1'b1});
    n = 0;
    @(negedge clk);
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    mode = 1'b0; sub = 1'b0; a = 16'h7351; b = 16'h1234;
    sb_q.push_back({16'h7575, 1'b1, 1'b0});
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b_spacing", n, 5);
    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
